// File: rtl/baud_tick_gen.sv
// Programmable baud tick generator: os_tick every div_act clocks, baud/mid-bit ticks from an os counter.
// Defining BAUD_FRAC_DIV_EN adds frac_in and a fractional-divisor accumulator.
module baud_tick_gen #(
  parameter int CNT_W       = 16,
  parameter int OSR_W       = 5,
  parameter int DEFAULT_DIV = 651,
  parameter int DEFAULT_OSR = 16,
  parameter int FRAC_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              load,
  input  logic [CNT_W-1:0]  div_in,
  input  logic [OSR_W-1:0]  osr_in,
`ifdef BAUD_FRAC_DIV_EN
  input  logic [FRAC_W-1:0] frac_in,
`endif
  input  logic              phase_sync,
  output logic              os_tick,
  output logic              baud_tick,
  output logic              mid_tick,
  output logic              cfg_pending
);

  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    return (d < CNT_W'(2)) ? CNT_W'(2) : d;
  endfunction

  function automatic logic [OSR_W-1:0] clamp_osr(input logic [OSR_W-1:0] o);
    return (o < OSR_W'(2)) ? OSR_W'(1) : o;
  endfunction

  localparam logic [CNT_W-1:0] RST_DIV = clamp_div(CNT_W'(DEFAULT_DIV));
  localparam logic [OSR_W-1:0] RST_OSR = clamp_osr(OSR_W'(DEFAULT_OSR));

  if (CNT_W < 2 || OSR_W < 2 || FRAC_W < 1) begin : g_param_check
    $error("baud_tick_gen: CNT_W and OSR_W must be >= 2, FRAC_W >= 1");
  end

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] div_shd;
  logic [CNT_W-1:0] cnt_last;
  logic [OSR_W-1:0] osc;
  logic [OSR_W-1:0] osr_act;
  logic [OSR_W-1:0] osr_shd;
  logic [OSR_W-1:0] osc_inc;
  logic [OSR_W-1:0] osr_half;
  logic             stretch;
  logic             cnt_wrap;
  logic             osc_wrap;
  logic             os_ev;
  logic             baud_ev;
  logic             mid_ev;
  logic             apply;

  // Tick decode: events that the output registers will present next cycle
  always_comb begin
    cnt_last = div_act - CNT_W'(1) + CNT_W'(stretch);
    osc_inc  = osc + OSR_W'(1);
    osr_half = osr_act >> 1;
    // >= keeps the counters safe if a config lands while frozen past the new terminal value
    cnt_wrap = (cnt >= cnt_last);
    osc_wrap = (osc >= osr_act - OSR_W'(1));
    os_ev    = en && cnt_wrap && !phase_sync;
    baud_ev  = os_ev && osc_wrap;
    mid_ev   = os_ev && !osc_wrap && (osr_act >= OSR_W'(2)) && (osc_inc == osr_half);
    apply    = cfg_pending && (phase_sync || baud_ev || !en);
  end

  // Counter and output register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      osc         <= '0;
      div_act     <= RST_DIV;
      osr_act     <= RST_OSR;
      os_tick     <= 1'b0;
      baud_tick   <= 1'b0;
      mid_tick    <= 1'b0;
      cfg_pending <= 1'b0;
    end else begin
      os_tick     <= os_ev;
      baud_tick   <= baud_ev;
      mid_tick    <= mid_ev;
      cfg_pending <= load || (cfg_pending && !apply);
      if (apply) begin
        div_act <= div_shd;
        osr_act <= osr_shd;
      end
      if (phase_sync) begin
        cnt <= '0;
        osc <= '0;
      end else if (en) begin
        if (cnt_wrap) begin
          cnt <= '0;
          osc <= osc_wrap ? '0 : osc_inc;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // Shadow config is only read while cfg_pending is set, so it needs no reset
  always_ff @(posedge clk) begin
    if (load) begin
      div_shd <= clamp_div(div_in);
      osr_shd <= clamp_osr(osr_in);
    end
  end

`ifdef BAUD_FRAC_DIV_EN
  logic [FRAC_W-1:0] frac_act;
  logic [FRAC_W-1:0] frac_shd;
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   acc_sum;

  assign acc_sum = {1'b0, acc} + {1'b0, frac_act};

  // Fractional stage: a carry out of acc stretches the following os period by one clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frac_act <= '0;
      acc      <= '0;
      stretch  <= 1'b0;
    end else begin
      if (apply) begin
        frac_act <= frac_shd;
      end
      if (phase_sync) begin
        acc     <= '0;
        stretch <= 1'b0;
      end else if (os_ev) begin
        acc     <= acc_sum[FRAC_W-1:0];
        stretch <= acc_sum[FRAC_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      frac_shd <= frac_in;
    end
  end
`else
  assign stretch = 1'b0;
`endif

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen (default build): tick timing, shadowed config, en freeze,
// phase_sync, clamping and asynchronous reset, all against hand-computed cycle numbers.
module tb_baud_tick_gen;

  typedef int iq_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        load;
  logic [15:0] div_in;
  logic [4:0]  osr_in;
  logic        phase_sync;
  logic        os_tick;
  logic        baud_tick;
  logic        mid_tick;
  logic        cfg_pending;

  int  n_vec = 0;
  int  n_err = 0;
  int  cyc   = 0;
  int  a     = 0;
  iq_t os_q;
  iq_t baud_q;
  iq_t mid_q;

  baud_tick_gen #(
    .CNT_W      (16),
    .OSR_W      (5),
    .DEFAULT_DIV(651),
    .DEFAULT_OSR(16),
    .FRAC_W     (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load       (load),
    .div_in     (div_in),
    .osr_in     (osr_in),
    .phase_sync (phase_sync),
    .os_tick    (os_tick),
    .baud_tick  (baud_tick),
    .mid_tick   (mid_tick),
    .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int q_at(input iq_t q, input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (os_tick)   os_q.push_back(cyc);
    if (baud_tick) baud_q.push_back(cyc);
    if (mid_tick)  mid_q.push_back(cyc);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clr();
    os_q.delete();
    baud_q.delete();
    mid_q.delete();
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; load = 1'b0; phase_sync = 1'b0;
    div_in = 16'd0; osr_in = 5'd0;

    // reset state
    run(3);
    chk("rst_os", os_tick, 0);
    chk("rst_baud", baud_tick, 0);
    chk("rst_mid", mid_tick, 0);
    chk("rst_pending", cfg_pending, 0);
    reset = 1'b0;
    run(3);
    chk("idle_os", os_tick, 0);

    // defaults: os every 651, mid at 8 os_ticks, baud at 16 os_ticks
    en = 1'b1; cyc = 0; clr();
    run(10416);
    chk("def_os0", q_at(os_q, 0), 651);
    chk("def_os1", q_at(os_q, 1), 1302);
    chk("def_mid0", q_at(mid_q, 0), 5208);
    chk("def_baud0", q_at(baud_q, 0), 10416);
    chk("def_os_cnt", os_q.size(), 16);
    chk("def_mid_cnt", mid_q.size(), 1);

    // load mid-bit: old timing until the baud boundary at 20832
    run(13000 - 10416); clr();
    load = 1'b1; div_in = 16'd4; osr_in = 5'd4;
    step(); load = 1'b0;
    chk("ld_pending_set", cfg_pending, 1);
    run(20831 - 13001);
    chk("ld_pending_hold", cfg_pending, 1);
    step();
    chk("ld_apply_baud", baud_tick, 1);
    chk("ld_pending_clr", cfg_pending, 0);
    chk("ld_old_os_cnt", os_q.size(), 13);
    clr();
    run(32);
    chk("new_os0", q_at(os_q, 0), 20836);
    chk("new_os1", q_at(os_q, 1), 20840);
    chk("new_mid0", q_at(mid_q, 0), 20840);
    chk("new_baud0", q_at(baud_q, 0), 20848);
    chk("new_baud1", q_at(baud_q, 1), 20864);

    // en low for 10 cycles at cnt=2; a load while frozen applies on the next edge
    run(2); clr();
    en = 1'b0;
    run(2);
    load = 1'b1; div_in = 16'd4; osr_in = 5'd4;
    step(); load = 1'b0;
    chk("frz_pending_set", cfg_pending, 1);
    step();
    chk("frz_pending_clr", cfg_pending, 0);
    run(6);
    chk("frz_no_ticks", os_q.size() + baud_q.size() + mid_q.size(), 0);
    en = 1'b1;
    run(2);
    chk("frz_resume_os", q_at(os_q, 0), 20878);

    // phase_sync where a wrap would otherwise happen
    run(3);
    phase_sync = 1'b1;
    step(); phase_sync = 1'b0;
    chk("ps_os_suppressed", os_tick, 0);
    clr();
    run(16);
    chk("ps_os0", q_at(os_q, 0), 20886);
    chk("ps_mid0", q_at(mid_q, 0), 20890);
    chk("ps_baud0", q_at(baud_q, 0), 20898);
    chk("ps_os_cnt", os_q.size(), 4);

    // clamping div 0 -> 2, osr 1 -> baud == os, applied by phase_sync
    run(2);
    load = 1'b1; div_in = 16'd0; osr_in = 5'd1;
    step(); load = 1'b0;
    chk("clmp_pending_set", cfg_pending, 1);
    phase_sync = 1'b1;
    step(); phase_sync = 1'b0;
    chk("clmp_pending_clr", cfg_pending, 0);
    clr();
    run(10);
    chk("clmp_os_cnt", os_q.size(), 5);
    chk("clmp_os0", q_at(os_q, 0), 20904);
    chk("clmp_baud_cnt", baud_q.size(), 5);
    chk("clmp_baud4", q_at(baud_q, 4), 20912);
    chk("clmp_mid_cnt", mid_q.size(), 0);

    // asynchronous reset mid-run
    chk("arst_pre_os", os_tick, 1);
    reset = 1'b1;
    #1;
    chk("arst_os", os_tick, 0);
    chk("arst_baud", baud_tick, 0);
    run(2);
    reset = 1'b0; cyc = 0; clr();
    run(1302);
    chk("arst_def_os0", q_at(os_q, 0), 651);
    chk("arst_def_os1", q_at(os_q, 1), 1302);

    // second load overwrites shadow; load together with apply keeps the new value pending
    a = cyc;
    load = 1'b1; div_in = 16'd5; osr_in = 5'd2;
    step();
    div_in = 16'd3;
    step(); load = 1'b0;
    chk("ovr_pending", cfg_pending, 1);
    phase_sync = 1'b1;
    step(); phase_sync = 1'b0;
    chk("ovr_pending_clr", cfg_pending, 0);
    clr();
    run(9);
    chk("ovr_os0", q_at(os_q, 0) - a, 6);
    chk("ovr_os1", q_at(os_q, 1) - a, 9);
    chk("ovr_mid0", q_at(mid_q, 0) - a, 6);
    chk("ovr_baud0", q_at(baud_q, 0) - a, 9);
    load = 1'b1; div_in = 16'd7;
    step();
    div_in = 16'd9; phase_sync = 1'b1;
    step(); load = 1'b0; phase_sync = 1'b0;
    chk("ldap_pending_stays", cfg_pending, 1);
    clr();
    run(7);
    chk("ldap_os_cnt", os_q.size(), 1);
    chk("ldap_os0", q_at(os_q, 0) - a, 21);
    phase_sync = 1'b1;
    step(); phase_sync = 1'b0;
    chk("ldap_pending_clr", cfg_pending, 0);
    clr();
    run(9);
    chk("ldap2_os_cnt", os_q.size(), 1);
    chk("ldap2_os0", q_at(os_q, 0) - a, 31);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
